// File: rtl/message_padder.sv
// Purpose : pads one message (up to MAX_MSG_LENGTH bytes) into a single 512-bit MD5 block and streams it as 16 x 32-bit words.
// Latency : first word valid the cycle after message acceptance; 16 words minimum, so at least 17 cycles per message.
// Backpr. : word_index/word_data hold while word_valid && !word_ready; msg_ready is low for the whole block.
//
// Ports:
//   clk, reset_n                      - clock, asynchronous active-low reset (release synchronously to clk)
//   msg_valid/msg_ready               - message handshake; msg_length in bytes, msg_data left-aligned
//                                       (byte i at [8*(MAX_MSG_LENGTH-1-i) +: 8])
//   word_valid/word_ready             - word handshake towards the MD5 core
//   word_index, word_data, word_last  - word position 0..15, little-endian packed word, last-word flag
//   oversize_error                    - sticky flag for messages longer than MAX_MSG_LENGTH
//
// Optional feature: define MSG_PADDER_LENGTH_CHECK_EN to discard oversize messages and raise
// oversize_error. Without it, oversize_error is tied to 0 and every accepted message is padded.
module message_padder #(
  parameter int MAX_MSG_LENGTH = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        msg_ready,
  input  logic                        msg_valid,
  input  logic [5:0]                  msg_length,
  input  logic [8*MAX_MSG_LENGTH-1:0] msg_data,
  input  logic                        word_ready,
  output logic                        word_valid,
  output logic [3:0]                  word_index,
  output logic [31:0]                 word_data,
  output logic                        word_last,
  output logic                        oversize_error
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [8*MAX_MSG_LENGTH-1:0] r_msg;
  logic [5:0]                  r_len;
  logic [3:0]                  r_idx;

  logic                        w_oversize;
  logic                        w_take;
  logic [8:0]                  w_bit_len;
  logic [7:0]                  w_msg_byte [64];
  logic [7:0]                  w_blk      [64];

`ifdef MSG_PADDER_LENGTH_CHECK_EN
  logic r_oversize;

  assign w_oversize     = (msg_length > 6'(MAX_MSG_LENGTH));
  assign oversize_error = r_oversize;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_oversize <= 1'b0;
    end else if (msg_valid && msg_ready && w_oversize) begin
      r_oversize <= 1'b1;
    end
  end
`else
  assign w_oversize     = 1'b0;
  assign oversize_error = 1'b0;
`endif

  // A message is captured only when it will actually be padded; oversize
  // messages are still handshaken (msg_ready is high) but dropped.
  assign w_take = msg_valid && msg_ready && !w_oversize;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs. word_valid is decoded straight from the
  // state so an asynchronous reset drops it in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    msg_ready   = 1'b0;
    word_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid && !w_oversize) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        word_valid = 1'b1;
        if (word_ready && (r_idx == 4'd15)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Captured message, length and word counter. The counter wraps 15 -> 0 on
  // the last handshake, so it is already 0 when the block returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg <= '0;
      r_len <= '0;
      r_idx <= '0;
    end else if (w_take) begin
      r_msg <= msg_data;
      r_len <= msg_length;
      r_idx <= '0;
    end else if (word_valid && word_ready) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  // Message bytes by block position; positions beyond the bus width read as 0.
  for (genvar gi = 0; gi < 64; gi++) begin : g_msg_byte
    if (gi < MAX_MSG_LENGTH) begin : g_in
      assign w_msg_byte[gi] = r_msg[8*(MAX_MSG_LENGTH-1-gi) +: 8];
    end else begin : g_out
      assign w_msg_byte[gi] = 8'h00;
    end
  end

  // Bit length 8*L fits in 9 bits for L <= 63; bytes 58..63 are always zero.
  assign w_bit_len = {r_len, 3'b000};

  // Full 64-byte padded block.
  always_comb begin
    for (int b = 0; b < 64; b++) begin
      if (b < int'(r_len)) begin
        w_blk[b] = w_msg_byte[b];
      end else if (b == int'(r_len)) begin
        w_blk[b] = 8'h80;
      end else if (b == 56) begin
        w_blk[b] = w_bit_len[7:0];
      end else if (b == 57) begin
        w_blk[b] = {7'b0, w_bit_len[8]};
      end else begin
        w_blk[b] = 8'h00;
      end
    end
  end

  // Word w carries block bytes 4w..4w+3, lowest byte in the low bits.
  assign word_data  = word_valid ? {w_blk[{r_idx, 2'd3}], w_blk[{r_idx, 2'd2}],
                                    w_blk[{r_idx, 2'd1}], w_blk[{r_idx, 2'd0}]}
                                 : 32'h0;
  assign word_index = r_idx;
  assign word_last  = word_valid && (r_idx == 4'd15);

endmodule

// File: tb/tb_message_padder.sv
module tb_message_padder;

  localparam int MA = 32;
  localparam int MB = 55;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;

  logic          a_msg_ready, a_msg_valid, a_word_ready, a_word_valid, a_word_last, a_oversize;
  logic [5:0]    a_msg_length;
  logic [8*MA-1:0] a_msg_data;
  logic [3:0]    a_word_index;
  logic [31:0]   a_word_data;

  logic          b_msg_ready, b_msg_valid, b_word_ready, b_word_valid, b_word_last, b_oversize;
  logic [5:0]    b_msg_length;
  logic [8*MB-1:0] b_msg_data;
  logic [3:0]    b_word_index;
  logic [31:0]   b_word_data;

  message_padder #(.MAX_MSG_LENGTH(MA)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .msg_ready(a_msg_ready), .msg_valid(a_msg_valid), .msg_length(a_msg_length), .msg_data(a_msg_data),
    .word_ready(a_word_ready), .word_valid(a_word_valid), .word_index(a_word_index),
    .word_data(a_word_data), .word_last(a_word_last), .oversize_error(a_oversize)
  );

  message_padder #(.MAX_MSG_LENGTH(MB)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .msg_ready(b_msg_ready), .msg_valid(b_msg_valid), .msg_length(b_msg_length), .msg_data(b_msg_data),
    .word_ready(b_word_ready), .word_valid(b_word_valid), .word_index(b_word_index),
    .word_data(b_word_data), .word_last(b_word_last), .oversize_error(b_oversize)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] dat;
    logic        last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: padded block byte b straight from the padding rules, then packed.
  function automatic logic [31:0] ref_word(input logic [7:0] m[64], input int len,
                                           input int maxl, input int w);
    logic [31:0] r;
    logic [63:0] bl;
    logic [7:0]  byt;
    int          b;
    r  = '0;
    bl = 64'(8 * len);
    for (int k = 0; k < 4; k++) begin
      b = 4 * w + k;
      if (b < len)       byt = (b < maxl) ? m[b] : 8'h00;
      else if (b == len) byt = 8'h80;
      else if (b >= 56)  byt = 8'(bl >> (8 * (b - 56)));
      else               byt = 8'h00;
      r[8*k +: 8] = byt;
    end
    return r;
  endfunction

  task automatic push_exp(input bit sel, input logic [7:0] m[64], input int len);
    exp_t e;
    for (int w = 0; w < 16; w++) begin
      e.idx  = 4'(w);
      e.dat  = ref_word(m, len, sel ? MB : MA, w);
      e.last = (w == 15);
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
    end
  endtask

  // Offer one message to DUT a (sel=0) or b (sel=1); returns just after the acceptance edge.
  task automatic send(input bit sel, input logic [7:0] m[64], input int len, input bit expect_words);
    int n;
    logic [8*MA-1:0] da;
    logic [8*MB-1:0] db;
    da = '0;
    db = '0;
    for (int i = 0; i < MA; i++) da[8*(MA-1-i) +: 8] = m[i];
    for (int i = 0; i < MB; i++) db[8*(MB-1-i) +: 8] = m[i];
    n = 0;
    @(posedge clk); #1;
    while (!(sel ? b_msg_ready : a_msg_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(sel ? b_msg_ready : a_msg_ready)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL msg_ready_timeout: dut %0d msg_ready 0 after %0d cycles, required 1", sel, n);
      return;
    end
    if (expect_words) push_exp(sel, m, len);
    if (sel) begin
      b_msg_valid = 1'b1; b_msg_length = 6'(len); b_msg_data = db;
    end else begin
      a_msg_valid = 1'b1; a_msg_length = 6'(len); a_msg_data = da;
    end
    @(posedge clk); #1;
    a_msg_valid = 1'b0;
    b_msg_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_word_valid && a_word_ready) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL a_unexpected_word: index %0d data 0x%08h, none required", a_word_index, a_word_data);
        end else begin
          e = qa.pop_front();
          chk("a_word_index", 64'(a_word_index), 64'(e.idx));
          chk("a_word_data", 64'(a_word_data), 64'(e.dat));
          chk("a_word_last", 64'(a_word_last), 64'(e.last));
          chk("a_msg_ready_in_emit", 64'(a_msg_ready), 64'd0);
        end
      end
      if (b_word_valid && b_word_ready) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_unexpected_word: index %0d data 0x%08h, none required", b_word_index, b_word_data);
        end else begin
          e = qb.pop_front();
          chk("b_word_index", 64'(b_word_index), 64'(e.idx));
          chk("b_word_data", 64'(b_word_data), 64'(e.dat));
          chk("b_word_last", 64'(b_word_last), 64'(e.last));
          chk("b_msg_ready_in_emit", 64'(b_msg_ready), 64'd0);
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #1;
      a_word_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      b_word_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    logic [7:0] m[64];
    string      s;
    int         cnt;
    int         len;

    reset_n      = 1'b0;
    a_msg_valid  = 1'b0; a_msg_length = '0; a_msg_data = '0; a_word_ready = 1'b1;
    b_msg_valid  = 1'b0; b_msg_length = '0; b_msg_data = '0; b_word_ready = 1'b1;
    for (int i = 0; i < 64; i++) m[i] = 8'h00;

    fork
      monitor();
      ready_driver();
    join_none

    // Reset state
    #12;
    chk("rst_word_valid", 64'(a_word_valid), 64'd0);
    chk("rst_word_index", 64'(a_word_index), 64'd0);
    chk("rst_word_data", 64'(a_word_data), 64'd0);
    chk("rst_word_last", 64'(a_word_last), 64'd0);
    chk("rst_oversize", 64'(a_oversize), 64'd0);
    chk("rst_msg_ready", 64'(a_msg_ready), 64'd1);
    chk("rst_b_word_valid", 64'(b_word_valid), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Known vector, L=12
    s = "abcdef609043";
    for (int i = 0; i < 12; i++) m[i] = s[i];
    send(1'b0, m, 12, 1'b1);
    drain();

    // Empty message and accept-to-next-accept spacing
    for (int i = 0; i < 64; i++) m[i] = 8'($urandom_range(0, 255));
    send(1'b0, m, 0, 1'b1);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!a_msg_ready && cnt < 100);
    chk("l0_accept_to_accept_cycles", 64'(cnt + 1), 64'd17);
    drain();

    // Full-width message on the 55-byte instance
    for (int i = 0; i < 64; i++) m[i] = 8'h61;
    send(1'b1, m, 55, 1'b1);
    drain();

    // Random messages with random downstream stalls
    rnd_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 64; i++) m[i] = 8'($urandom_range(0, 255));
      len = (t == 0) ? MA : int'($urandom_range(0, MA));
      send(1'b0, m, len, 1'b1);
      for (int i = 0; i < 64; i++) m[i] = 8'($urandom_range(0, 255));
      len = (t == 0) ? MB : int'($urandom_range(0, MB));
      send(1'b1, m, len, 1'b1);
    end
    drain();

    // Reset during word 7
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 64; i++) m[i] = 8'($urandom_range(0, 255));
    send(1'b0, m, 20, 1'b1);
    cnt = 0;
    while (!(a_word_valid && a_word_index == 4'd7) && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("reached_word7", 64'(a_word_index), 64'd7);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_word_valid", 64'(a_word_valid), 64'd0);
    chk("midrst_word_index", 64'(a_word_index), 64'd0);
    chk("midrst_msg_ready", 64'(a_msg_ready), 64'd1);
    qa.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) m[i] = s[i];
    send(1'b0, m, 12, 1'b1);
    drain();

`ifdef MSG_PADDER_LENGTH_CHECK_EN
    send(1'b0, m, 40, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("oversize_flag", 64'(a_oversize), 64'd1);
    chk("oversize_stays_idle", 64'(a_msg_ready), 64'd1);
    send(1'b0, m, 12, 1'b1);
    drain();
    chk("oversize_flag_held", 64'(a_oversize), 64'd1);
`else
    chk("oversize_tied_low", 64'(a_oversize), 64'd0);
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
